// File: rtl/alu_pkg.sv
// Shared types and constants for the 4-op ALU and its operand sequencer.
package alu_pkg;

    typedef enum logic [2:0] {
        WAIT_A  = 3'b000,
        WAIT_B  = 3'b001,
        WAIT_OP = 3'b010,
        EXEC    = 3'b011,
        SHOW    = 3'b100
    } seq_state_t;

    localparam logic [1:0] OP_NOR  = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_SUB  = 2'b11;

    // Bit positions inside the 5-bit flag vector {V,C,Z,N,P}.
    localparam int FLG_V = 4;
    localparam int FLG_C = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_N = 1;
    localparam int FLG_P = 0;

endpackage

// File: rtl/rise_edge_detect.sv
// Single-cycle pulse on each 0->1 transition of a level input.
module rise_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic in,
    output logic pulse
);

    logic in_q;
    logic in_d;

    always_comb begin
        in_d = in;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in_d;
        end
    end

    assign pulse = in & ~in_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Captures A, B and OpCode from one switch bank on successive load presses,
// then latches the ALU result/flags and counts executions.
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int M     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [M-1:0]     sw,
    input  logic             load_btn,
    input  logic             clear_btn,
    output logic [M-1:0]     A,
    output logic [M-1:0]     B,
    output logic [1:0]       OpCode,
    input  logic [M-1:0]     alu_result,
    input  logic [4:0]       alu_flags,
    output logic [M-1:0]     result_q,
    output logic [4:0]       flags_q,
    output logic [2:0]       state,
    output logic             done,
    output logic [CNT_W-1:0] op_count
);

    seq_state_t       state_q, state_d;
    logic [M-1:0]     a_q, a_d;
    logic [M-1:0]     b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [M-1:0]     res_q, res_d;
    logic [4:0]       flg_q, flg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_pulse;
    logic             state_legal;

    rise_edge_detect u_load_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .in      (load_btn),
        .pulse   (load_pulse)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        res_d       = res_q;
        flg_d       = flg_q;
        cnt_d       = cnt_q;
        state_legal = state_q inside {WAIT_A, WAIT_B, WAIT_OP, EXEC, SHOW};

        if (!state_legal) begin
            state_d = WAIT_A;
        end else if (clear_btn) begin
            // Clear aborts the sequence but keeps the last displayed result.
            state_d = WAIT_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
        end else begin
            case (state_q)
                WAIT_A, SHOW: begin
                    if (load_pulse) begin
                        a_d     = sw;
                        state_d = WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (load_pulse) begin
                        b_d     = sw;
                        state_d = WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (load_pulse) begin
                        op_d    = sw[1:0];
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    // Operands have been stable for the whole cycle; a press here is dropped.
                    res_d   = alu_result;
                    flg_d   = alu_flags;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = SHOW;
                end
                default: state_d = WAIT_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign OpCode   = op_q;
    assign result_q = res_q;
    assign flags_q  = flg_q;
    assign state    = state_q;
    assign done     = (state_q == SHOW);
    assign op_count = cnt_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer with an attached behavioural ALU and a step-level reference model.
module tb_alu_operand_sequencer;

    localparam int M     = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [M-1:0]     sw;
    logic             load_btn;
    logic             clear_btn;
    logic [M-1:0]     A, B;
    logic [1:0]       OpCode;
    logic [M-1:0]     alu_result;
    logic [4:0]       alu_flags;
    logic [M-1:0]     result_q;
    logic [4:0]       flags_q;
    logic [2:0]       state;
    logic             done;
    logic [CNT_W-1:0] op_count;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: phase 0..4 = waiting A, waiting B, waiting op, executing, showing
    int               m_phase;
    logic [M-1:0]     m_a, m_b, m_res;
    logic [1:0]       m_op;
    logic [4:0]       m_flags;
    logic [CNT_W-1:0] m_cnt;
    logic             m_prev;

    always #5 clk = ~clk;

    alu_operand_sequencer #(.M(M), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sw         (sw),
        .load_btn   (load_btn),
        .clear_btn  (clear_btn),
        .A          (A),
        .B          (B),
        .OpCode     (OpCode),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .result_q   (result_q),
        .flags_q    (flags_q),
        .state      (state),
        .done       (done),
        .op_count   (op_count)
    );

    // Behavioural ALU: returns {result, V, C, Z, N, P}; P is odd parity of the result.
    function automatic logic [M+4:0] alu_fn(input logic [M-1:0] a, input logic [M-1:0] b,
                                            input logic [1:0] op);
        logic [M-1:0] r;
        logic         v, c;
        v = 1'b0;
        c = 1'b0;
        case (op)
            2'b00: r = ~(a | b);
            2'b01: r = ~(a & b);
            2'b10: begin
                {c, r} = {1'b0, a} + {1'b0, b};
                v = (a[M-1] == b[M-1]) && (r[M-1] != a[M-1]);
            end
            default: begin
                r = a - b;
                c = (a < b);
                v = (a[M-1] != b[M-1]) && (r[M-1] != a[M-1]);
            end
        endcase
        return {r, v, c, (r == '0), r[M-1], ^r};
    endfunction

    always_comb begin
        {alu_result, alu_flags} = alu_fn(A, B, OpCode);
    end

    // Drive one cycle of inputs, advance the model across the edge, sample 1ns later.
    task automatic step(input logic [M-1:0] s, input logic ld, input logic clr);
        logic pulse;
        sw        = s;
        load_btn  = ld;
        clear_btn = clr;
        @(posedge clk);
        pulse = ld && !m_prev;
        if (!reset_n) begin
            m_phase = 0; m_a = '0; m_b = '0; m_op = '0;
            m_res = '0; m_flags = '0; m_cnt = '0;
            m_prev = 1'b0;
        end else begin
            m_prev = ld;
            if (clr) begin
                m_phase = 0; m_a = '0; m_b = '0; m_op = '0;
            end else if (m_phase == 3) begin
                {m_res, m_flags} = alu_fn(m_a, m_b, m_op);
                m_cnt   = m_cnt + 1'b1;
                m_phase = 4;
            end else if (pulse) begin
                if (m_phase == 0 || m_phase == 4) begin m_a = s; m_phase = 1; end
                else if (m_phase == 1) begin m_b = s; m_phase = 2; end
                else begin m_op = s[1:0]; m_phase = 3; end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        n_tests++; if (state !== 3'b000) begin n_fail++; $display("FAIL reset_state got %b want 000", state); end
        n_tests++; if ({A, B, OpCode} !== '0) begin n_fail++; $display("FAIL reset_operands got %h/%h/%h want 0", A, B, OpCode); end
        n_tests++; if (result_q !== 8'h00 || flags_q !== 5'b00000) begin n_fail++; $display("FAIL reset_result got %h/%b want 00/00000", result_q, flags_q); end
        n_tests++; if (op_count !== 8'h00 || done !== 1'b0) begin n_fail++; $display("FAIL reset_count_done got %h/%b want 00/0", op_count, done); end
        reset_n = 1'b1;
    endtask

    task automatic test_add();
        step(8'h7F, 1'b1, 1'b0); step(8'h7F, 1'b0, 1'b0);
        step(8'h01, 1'b1, 1'b0); step(8'h01, 1'b0, 1'b0);
        step(8'h02, 1'b1, 1'b0);
        n_tests++; if (state !== 3'b011 || done !== 1'b0) begin n_fail++; $display("FAIL add_exec_state got %b/%b want 011/0", state, done); end
        n_tests++; if (A !== 8'h7F || B !== 8'h01 || OpCode !== 2'b10) begin n_fail++; $display("FAIL add_operands got %h/%h/%b want 7f/01/10", A, B, OpCode); end
        step(8'h02, 1'b0, 1'b0);
        n_tests++; if (result_q !== 8'h80 || flags_q !== 5'b10011) begin n_fail++; $display("FAIL add_result got %h/%b want 80/10011", result_q, flags_q); end
        n_tests++; if (done !== 1'b1 || state !== 3'b100 || op_count !== 8'd1) begin n_fail++; $display("FAIL add_show got done=%b st=%b cnt=%0d want 1/100/1", done, state, op_count); end
    endtask

    task automatic test_sub_from_show();
        step(8'h05, 1'b1, 1'b0);
        n_tests++; if (A !== 8'h05 || state !== 3'b001) begin n_fail++; $display("FAIL show_reload got A=%h st=%b want 05/001", A, state); end
        step(8'h05, 1'b0, 1'b0);
        step(8'h05, 1'b1, 1'b0); step(8'h05, 1'b0, 1'b0);
        step(8'h03, 1'b1, 1'b0); step(8'h03, 1'b0, 1'b0);
        n_tests++; if (result_q !== 8'h00 || flags_q !== 5'b00100) begin n_fail++; $display("FAIL sub_result got %h/%b want 00/00100", result_q, flags_q); end
        n_tests++; if (op_count !== 8'd2 || done !== 1'b1) begin n_fail++; $display("FAIL sub_count got %0d/%b want 2/1", op_count, done); end
    endtask

    task automatic test_held_button();
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(8'h33, 1'b1, 1'b0);
        n_tests++; if (A !== 8'h33 || state !== 3'b001 || B !== 8'h00) begin n_fail++; $display("FAIL held_single got A=%h B=%h st=%b want 33/00/001", A, B, state); end
        step(8'h33, 1'b0, 1'b0);
        step(8'h44, 1'b1, 1'b0);
        n_tests++; if (B !== 8'h44 || state !== 3'b010) begin n_fail++; $display("FAIL held_repress got B=%h st=%b want 44/010", B, state); end
        step(8'h44, 1'b0, 1'b0);
    endtask

    task automatic test_clear_load();
        step(8'h99, 1'b1, 1'b1);
        n_tests++; if (state !== 3'b000 || {A, B, OpCode} !== '0) begin n_fail++; $display("FAIL clear_abort got st=%b A=%h B=%h op=%b want 000/0/0/0", state, A, B, OpCode); end
        n_tests++; if (result_q !== 8'h00 || flags_q !== 5'b00100 || op_count !== 8'd2) begin n_fail++; $display("FAIL clear_retain got %h/%b/%0d want 00/00100/2", result_q, flags_q, op_count); end
        step(8'h99, 1'b1, 1'b0);
        n_tests++; if (state !== 3'b000 || A !== 8'h00) begin n_fail++; $display("FAIL clear_consumed got st=%b A=%h want 000/00", state, A); end
        step('0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [42:0] got, exp;
        logic        clr;
        for (int i = 0; i < 400; i++) begin
            clr = (m_phase != 3) && ($urandom_range(0, 19) == 0);
            step(M'($urandom), 1'($urandom_range(0, 1)), clr);
            got = {A, B, OpCode, result_q, flags_q, state, done, op_count};
            exp = {m_a, m_b, m_op, m_res, m_flags, 3'(m_phase), (m_phase == 4), m_cnt};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_cycle%0d got %h want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_wrap();
        int          n;
        logic [M-1:0] v;
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0);
        n = 256 - int'(m_cnt);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 3; k++) begin
                v = M'($urandom);
                step(v, 1'b1, 1'b0);
                step(v, 1'b0, 1'b0);
            end
            n_tests++;
            if (result_q !== m_res || flags_q !== m_flags || op_count !== m_cnt || done !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_exec%0d got %h/%b/%h want %h/%b/%h", i, result_q, flags_q, op_count, m_res, m_flags, m_cnt);
            end
            if (i == n - 2) begin
                n_tests++; if (op_count !== 8'hFF) begin n_fail++; $display("FAIL wrap_max got %h want ff", op_count); end
            end
        end
        n_tests++; if (op_count !== 8'h00) begin n_fail++; $display("FAIL wrap_zero got %h want 00", op_count); end
    endtask

    task automatic test_reset_mid();
        step(8'h11, 1'b1, 1'b0);
        step(8'h11, 1'b0, 1'b0);
        n_tests++; if (state !== 3'b001 || A !== 8'h11) begin n_fail++; $display("FAIL mid_setup got st=%b A=%h want 001/11", state, A); end
        reset_n = 1'b0;
        step(8'h22, 1'b1, 1'b0);
        n_tests++; if ({state, A, B, OpCode, done} !== '0) begin n_fail++; $display("FAIL mid_reset_ctl got st=%b A=%h B=%h op=%b done=%b want 0", state, A, B, OpCode, done); end
        n_tests++; if (result_q !== 8'h00 || flags_q !== 5'b00000 || op_count !== 8'h00) begin n_fail++; $display("FAIL mid_reset_res got %h/%b/%h want 0", result_q, flags_q, op_count); end
        reset_n = 1'b1;
        step('0, 1'b0, 1'b0);
        step(8'h5A, 1'b1, 1'b0);
        n_tests++; if (A !== 8'h5A || state !== 3'b001) begin n_fail++; $display("FAIL post_reset_press got A=%h st=%b want 5a/001", A, state); end
    endtask

    initial begin
        reset_n   = 1'b0;
        sw        = '0;
        load_btn  = 1'b0;
        clear_btn = 1'b0;
        m_phase = 0; m_a = '0; m_b = '0; m_op = '0;
        m_res = '0; m_flags = '0; m_cnt = '0; m_prev = 1'b0;
        test_reset();
        test_add();
        test_sub_from_show();
        test_held_button();
        test_clear_load();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
